bcd2bin: RTL and testbench
==========================

Name: bcd2bin

Overview:
- Sequential 5-digit packed BCD to 16-bit binary converter using reverse double dabble: shift right, then subtract 3 from any digit >= 8.
- It is the decode-direction partner of the binary-to-BCD display path. It converts keypad/decimal-entry values into binary operands for the processor datapath.
- One conversion per start pulse, with a fixed latency, a done pulse and status flags.

Parameters:
- None. Widths are fixed: 5 BCD digits (20 bits) in, 16 bits out.

Ports:
- clock  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high; overrides every other input
- start  input  1  sampled only in IDLE; launches a conversion
- bcd  input  20  packed BCD, digit 0 = bcd[3:0], digit 4 = bcd[19:16]; sampled on the start edge only
- bin  output  16  result register; holds its value until the next completed conversion
- busy  output  1  high from the cycle after start is accepted until return to IDLE
- done  output  1  one-cycle pulse when bin, overflow and error become valid
- overflow  output  1  BCD value > 65535; bin then holds value mod 65536
- error  output  1  some input digit > 9; bin forced to 0

Behaviour:
- Reset (synchronous): state=IDLE, bin=0, busy=0, done=0, overflow=0, error=0, internal counters=0. Reset mid-conversion aborts it; no done is produced.
- Internal registers:
  - r_bcd[19:0]: working BCD
  - r_bin[15:0]: working binary
  - i[3:0]: shift count
  - d[2:0]: digit index
- IDLE:
  - start=1 on an edge: latch r_bcd<=bcd, r_bin<=0, i<=0, d<=0, clear overflow and error.
  - If any digit of bcd is > 9: go to DONE, error<=1, bin<=0.
  - Otherwise go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (1 cycle): {r_bcd,r_bin} <= {r_bcd,r_bin} >> 1 (bcd bit 0 enters bin bit 15).
  - If i==15: go to DONE.
    - bin <= shifted binary value, i.e. {r_bcd[0], r_bin[15:1]}.
    - overflow <= (r_bcd>>1) != 0.
  - Else: i<=i+1, d<=0, go to ADJUST.
- ADJUST (1 cycle per digit, d=0..4):
  - If r_bcd digit d >= 8: digit d <= digit d - 3, computed 4-bit with no carry into the neighbouring digit.
  - If d==4: go to SHIFT. Else d<=d+1.
- DONE (1 cycle): done=1, busy=0, then go to IDLE. bin, overflow and error hold until the next accepted start.
- busy=1 in SHIFT and ADJUST.
- start while busy or in DONE is ignored; it is not queued.
- Latency (valid input):
  - 16 SHIFT cycles + 15x5 ADJUST cycles = 91 cycles.
  - done is high in the cycle following the 91st edge after the start-sampling edge.
  - A new start is accepted earliest 1 cycle after done.
- Latency (error): done is high in the cycle after the start edge. No shifting occurs.
- Input value 0 follows the full 91-cycle path; there is no early exit.
- done, overflow and error are registered outputs, with no combinational path from inputs.

Test Plan:
- bcd=20'h00000, start 1 cycle -> done 91 cycles later, bin=16'h0000, overflow=0, error=0; busy high during cycles 1..91.
- bcd=20'h65535 -> bin=16'hFFFF, overflow=0. Then bcd=20'h12345 -> bin=16'h3039 (12345), overflow=0.
- bcd=20'h65536 -> bin=16'h0000, overflow=1. bcd=20'h99999 -> bin=16'h869F (34463), overflow=1.
- bcd=20'h1A000 -> done 1 cycle after start, error=1, bin=16'h0000, overflow=0.
- Start with bcd=20'h00042 and hold start high throughout:
  - conversions run back-to-back, each gives bin=16'h002A;
  - each later start is accepted only in IDLE, 1 cycle after done.
- Reset asserted at cycle 40 of a conversion of bcd=20'h54321 -> next cycle: busy=0, done=0, bin=0. No done appears later. A fresh start then completes normally with bin=16'hD431 (54321).

Source files
------------

// File: rtl/bcd2bin.sv
// bcd2bin: converts a 5-digit packed BCD value into a 16-bit binary operand
//   using reverse double dabble (shift right, then subtract 3 from any digit >= 8).
// Ports:
//   clock, reset    : posedge clock, synchronous active-high reset (wins over all inputs)
//   start, bcd      : start launches a conversion from IDLE; bcd is captured on that edge
//   bin             : result register; holds until the next completed conversion
//   busy, done      : busy while shifting/adjusting; done pulses one cycle when results are valid
//   overflow, error : input value > 65535 (bin = value mod 65536) / an input digit > 9 (bin = 0)
// Latency: 91 cycles from the start edge to done for valid input; 1 cycle for error input.
// Backpressure: none. start is ignored while busy or during the done cycle and is not queued.

module bcd2bin (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [19:0] bcd,
  output logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        error
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_ADJUST = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [19:0] wbcd_q,  wbcd_d;   // working BCD, drained one bit per shift
  logic [15:0] wbin_q,  wbin_d;   // working binary, filled from the top
  logic [3:0]  cnt_q,   cnt_d;    // shift count
  logic [2:0]  dig_q,   dig_d;    // digit index during ADJUST
  logic [15:0] bin_q,   bin_d;
  logic        ovf_q,   ovf_d;
  logic        err_q,   err_d;

  logic        in_bad;

  // Any nibble of the incoming word above 9 makes the input invalid.
  always_comb begin
    in_bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bcd[4*k +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wbcd_d  = wbcd_q;
    wbin_d  = wbin_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          wbcd_d = bcd;
          wbin_d = 16'd0;
          cnt_d  = 4'd0;
          dig_d  = 3'd0;
          ovf_d  = 1'b0;
          err_d  = 1'b0;
          if (in_bad) begin
            err_d   = 1'b1;
            bin_d   = 16'd0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        {wbcd_d, wbin_d} = {wbcd_q, wbin_q} >> 1;
        if (cnt_q == 4'd15) begin
          // Last shift: publish directly; whatever remains in the BCD
          // register is the part of the value above 16 bits.
          bin_d   = {wbcd_q[0], wbin_q[15:1]};
          ovf_d   = (wbcd_q[19:1] != 19'd0);
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          dig_d   = 3'd0;
          state_d = ST_ADJUST;
        end
      end

      ST_ADJUST: begin
        // A digit >= 8 after a right shift received a 1 from the digit above,
        // worth 5 here rather than 8; subtracting 3 restores decimal weighting.
        // The subtract stays inside the nibble (no borrow across digits).
        for (int k = 0; k < 5; k++) begin
          if ((dig_q == 3'(k)) && (wbcd_q[4*k +: 4] >= 4'd8)) begin
            wbcd_d[4*k +: 4] = wbcd_q[4*k +: 4] - 4'd3;
          end
        end
        if (dig_q == 3'd4) begin
          state_d = ST_SHIFT;
        end else begin
          dig_d = dig_q + 3'd1;
        end
      end

      default: begin  // ST_DONE
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wbcd_q  <= 20'd0;
      wbin_q  <= 16'd0;
      cnt_q   <= 4'd0;
      dig_q   <= 3'd0;
      bin_q   <= 16'd0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wbcd_q  <= wbcd_d;
      wbin_q  <= wbin_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Status is decoded from the state register only, so no input reaches
  // these outputs combinationally.
  assign busy     = (state_q == ST_SHIFT) || (state_q == ST_ADJUST);
  assign done     = (state_q == ST_DONE);
  assign bin      = bin_q;
  assign overflow = ovf_q;
  assign error    = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin: self-checking bench for bcd2bin.
//   Directed corner values, back-to-back starts, mid-conversion reset and a
//   randomized sweep, all checked against a decimal-arithmetic reference.

module tb_bcd2bin;

  logic        clock;
  logic        reset;
  logic        start;
  logic [19:0] bcd;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  bcd2bin dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bcd      (bcd),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .error    (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: read the digits as a decimal number with plain arithmetic.
  function automatic void model(input logic [19:0] b, output logic [15:0] eb,
                                output logic eo, output logic ee);
    int v;
    int dg;
    v  = 0;
    ee = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      dg = int'(b[4*k +: 4]);
      if (dg > 9) ee = 1'b1;
      v = v * 10 + dg;
    end
    if (ee) begin
      eb = 16'd0;
      eo = 1'b0;
    end else begin
      eb = v[15:0];
      eo = (v > 65535);
    end
  endfunction

  // One start pulse, then wait (bounded) for done and check everything.
  task automatic do_conv(input logic [19:0] b, input string tag);
    logic [15:0] eb;
    logic        eo, ee;
    int          cnt, busy_err;
    bit          seen;
    model(b, eb, eo, ee);
    @(negedge clock);
    bcd   = b;
    start = 1'b1;
    cnt = 0; busy_err = 0; seen = 0;
    while (cnt < 200 && !seen) begin
      @(negedge clock);
      cnt++;
      if (cnt == 1) start = 1'b0;
      if (done) seen = 1;
      else if (!busy) busy_err++;
    end
    chk({tag, ".latency"}, seen ? cnt - 1 : -1, ee ? 0 : 91);
    chk({tag, ".bin"}, 32'(bin), 32'(eb));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
    chk({tag, ".error"}, 32'(error), 32'(ee));
    chk({tag, ".busy_at_done"}, 32'(busy), 0);
    chk({tag, ".busy_gaps"}, busy_err, 0);
    @(negedge clock);
    chk({tag, ".done_pulse"}, 32'(done), 0);
    chk({tag, ".bin_hold"}, 32'(bin), 32'(eb));
  endtask

  initial begin
    logic [19:0] rb;
    int          cnt, ndone;
    bit          seen;

    reset = 1'b1;
    start = 1'b0;
    bcd   = 20'd0;
    repeat (3) @(negedge clock);
    chk("reset.bin", 32'(bin), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.done", 32'(done), 0);
    chk("reset.overflow", 32'(overflow), 0);
    chk("reset.error", 32'(error), 0);
    reset = 1'b0;

    do_conv(20'h00000, "zero");
    do_conv(20'h65535, "max");
    do_conv(20'h12345, "12345");
    do_conv(20'h65536, "ovf_min");
    do_conv(20'h99999, "ovf_max");
    do_conv(20'h1A000, "err_d3");
    do_conv(20'h00042, "after_err");
    do_conv(20'hF0000, "err_d4");
    do_conv(20'h0000A, "err_d0");

    // start held high: back-to-back conversions, each accepted from IDLE.
    @(negedge clock);
    bcd   = 20'h00042;
    start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cnt = 0; seen = 0;
      while (cnt < 300 && !seen) begin
        @(negedge clock);
        cnt++;
        if (n > 0 && cnt == 1) chk("hold.idle_gap_busy", 32'(busy), 0);
        if (n > 0 && cnt == 2) chk("hold.accept_busy", 32'(busy), 1);
        if (done) seen = 1;
      end
      chk("hold.spacing", seen ? cnt : -1, (n == 0) ? 92 : 93);
      chk("hold.bin", 32'(bin), 32'h002A);
    end
    start = 1'b0;
    repeat (2) @(negedge clock);

    // Reset mid-conversion aborts with no done.
    bcd   = 20'h54321;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (39) @(negedge clock);
    chk("abort.busy_before", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("abort.busy", 32'(busy), 0);
    chk("abort.done", 32'(done), 0);
    chk("abort.bin", 32'(bin), 0);
    reset = 1'b0;
    ndone = 0;
    repeat (150) begin
      @(negedge clock);
      if (done || busy) ndone++;
    end
    chk("abort.no_activity", ndone, 0);
    do_conv(20'h54321, "post_abort");

    // Randomized sweep: mostly valid digits, some raw 20-bit words.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        rb = 20'($urandom);
      end else begin
        for (int k = 0; k < 5; k++) rb[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      do_conv(rb, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
